// File: rtl/sodor_arb_pkg.sv
// Shared types for the Sodor imem/dmem memory arbiter: FSM states, owners, memory op codes.
package sodor_arb_pkg;
    localparam int TYP_W = 3;
    localparam logic [TYP_W-1:0] MT_W = 3'b011;

    typedef enum logic {M_XRD = 1'b0, M_XWR = 1'b1} fcn_e;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/sodor_arb_prio.sv
// Grant decision: dmem priority with an imem starvation bound; grants are combinational,
// only the starvation counter is registered.
module sodor_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic imem_valid,
    input  logic dmem_valid,
    input  logic issue_ok,
    input  logic hs_i,
    input  logic hs_d,
    output logic grant_i,
    output logic grant_d
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == LIMIT) && imem_valid;
    assign grant_d = issue_ok && dmem_valid && !starved;
    assign grant_i = issue_ok && imem_valid && !grant_d;

    // Counts only dmem wins that actually kept a waiting fetch out.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (hs_i) begin
            starve_cnt <= '0;
        end else if (hs_d && imem_valid && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/sodor_mem_arbiter.sv
// Shares one memory port between Sodor imem/dmem, one transaction outstanding, zero-latency
// request and response paths; losers hold. SODOR_ARB_PERF_EN adds grant/conflict counters.
module sodor_mem_arbiter
    import sodor_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_imem_req_valid,
    output logic              io_imem_req_ready,
    input  logic [ADDR_W-1:0] io_imem_req_bits_addr,
    output logic              io_imem_resp_valid,
    output logic [DATA_W-1:0] io_imem_resp_bits_data,
    input  logic              io_dmem_req_valid,
    output logic              io_dmem_req_ready,
    input  logic [ADDR_W-1:0] io_dmem_req_bits_addr,
    input  logic [DATA_W-1:0] io_dmem_req_bits_data,
    input  logic              io_dmem_req_bits_fcn,
    input  logic [TYP_W-1:0]  io_dmem_req_bits_typ,
    output logic              io_dmem_resp_valid,
    output logic [DATA_W-1:0] io_dmem_resp_bits_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_bits_addr,
    output logic [DATA_W-1:0] mem_req_bits_data,
    output logic              mem_req_bits_fcn,
    output logic [TYP_W-1:0]  mem_req_bits_typ,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_bits_data,
    output logic              err_spurious_resp
`ifdef SODOR_ARB_PERF_EN
    ,
    output logic [31:0]       perf_imem_grants,
    output logic [31:0]       perf_dmem_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);
    state_e state, state_nxt;
    owner_e gnt;
    logic   issue_ok, grant_i, grant_d, hs_i, hs_d;

    // A response in a busy state frees the port in the same cycle (back-to-back issue).
    assign issue_ok = !reset && ((state == IDLE) || mem_resp_valid);

    sodor_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (io_imem_req_valid),
        .dmem_valid (io_dmem_req_valid),
        .issue_ok   (issue_ok),
        .hs_i       (hs_i),
        .hs_d       (hs_d),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    assign gnt = grant_d ? OWN_D : (grant_i ? OWN_I : OWN_NONE);

    always_comb begin
        mem_req_valid     = 1'b0;
        mem_req_bits_addr = '0;
        mem_req_bits_data = '0;
        mem_req_bits_fcn  = M_XRD;
        mem_req_bits_typ  = MT_W;
        case (gnt)
            OWN_D: begin
                mem_req_valid     = 1'b1;
                mem_req_bits_addr = io_dmem_req_bits_addr;
                mem_req_bits_data = io_dmem_req_bits_data;
                mem_req_bits_fcn  = io_dmem_req_bits_fcn;
                mem_req_bits_typ  = io_dmem_req_bits_typ;
            end
            OWN_I: begin
                mem_req_valid     = 1'b1;
                mem_req_bits_addr = io_imem_req_bits_addr;
            end
            default: ;
        endcase
    end

    assign io_imem_req_ready = grant_i && mem_req_ready;
    assign io_dmem_req_ready = grant_d && mem_req_ready;
    assign hs_i              = io_imem_req_ready;
    assign hs_d              = io_dmem_req_ready;

    assign io_imem_resp_valid     = mem_resp_valid && (state == BUSY_I);
    assign io_dmem_resp_valid     = mem_resp_valid && (state == BUSY_D);
    assign io_imem_resp_bits_data = mem_resp_bits_data;
    assign io_dmem_resp_bits_data = mem_resp_bits_data;

    always_comb begin
        state_nxt = state;
        if (hs_d) begin
            state_nxt = BUSY_D;
        end else if (hs_i) begin
            state_nxt = BUSY_I;
        end else if (mem_resp_valid && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            err_spurious_resp <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mem_resp_valid && state == IDLE) begin
                err_spurious_resp <= 1'b1;
            end
        end
    end

`ifdef SODOR_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_imem_grants     <= '0;
            perf_dmem_grants     <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (hs_i) perf_imem_grants <= perf_imem_grants + 32'd1;
            if (hs_d) perf_dmem_grants <= perf_dmem_grants + 32'd1;
            if (issue_ok && io_imem_req_valid && io_dmem_req_valid) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Bench for sodor_mem_arbiter: directed vector table, hand sequences for starvation/reset,
// then randomized traffic against a transaction-level reference model.
module tb_sodor_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_imem_req_valid, io_imem_req_ready, io_imem_resp_valid;
    logic [31:0] io_imem_req_bits_addr, io_imem_resp_bits_data;
    logic        io_dmem_req_valid, io_dmem_req_ready, io_dmem_resp_valid;
    logic [31:0] io_dmem_req_bits_addr, io_dmem_req_bits_data, io_dmem_resp_bits_data;
    logic        io_dmem_req_bits_fcn;
    logic [2:0]  io_dmem_req_bits_typ;
    logic        mem_req_valid, mem_req_ready, mem_req_bits_fcn, mem_resp_valid;
    logic [31:0] mem_req_bits_addr, mem_req_bits_data, mem_resp_bits_data;
    logic [2:0]  mem_req_bits_typ;
    logic        err_spurious_resp;

    always #5 clock = ~clock;

    sodor_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_imem_req_valid      (io_imem_req_valid),
        .io_imem_req_ready      (io_imem_req_ready),
        .io_imem_req_bits_addr  (io_imem_req_bits_addr),
        .io_imem_resp_valid     (io_imem_resp_valid),
        .io_imem_resp_bits_data (io_imem_resp_bits_data),
        .io_dmem_req_valid      (io_dmem_req_valid),
        .io_dmem_req_ready      (io_dmem_req_ready),
        .io_dmem_req_bits_addr  (io_dmem_req_bits_addr),
        .io_dmem_req_bits_data  (io_dmem_req_bits_data),
        .io_dmem_req_bits_fcn   (io_dmem_req_bits_fcn),
        .io_dmem_req_bits_typ   (io_dmem_req_bits_typ),
        .io_dmem_resp_valid     (io_dmem_resp_valid),
        .io_dmem_resp_bits_data (io_dmem_resp_bits_data),
        .mem_req_valid          (mem_req_valid),
        .mem_req_ready          (mem_req_ready),
        .mem_req_bits_addr      (mem_req_bits_addr),
        .mem_req_bits_data      (mem_req_bits_data),
        .mem_req_bits_fcn       (mem_req_bits_fcn),
        .mem_req_bits_typ       (mem_req_bits_typ),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_bits_data     (mem_resp_bits_data),
        .err_spurious_resp      (err_spurious_resp)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dd;
        logic        fcn;
        logic [2:0]  typ;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic [5:0]  e_flags;
        logic        chk_req;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_fcn;
        logic [2:0]  e_typ;
    } vec_t;

    vec_t tbl[15];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {mem_req_valid, imem_ready, dmem_ready, imem_resp_valid, dmem_resp_valid, err}
    function automatic logic [5:0] flags();
        return {mem_req_valid, io_imem_req_ready, io_dmem_req_ready,
                io_imem_resp_valid, io_dmem_resp_valid, err_spurious_resp};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic [31:0] da, input logic [31:0] dd, input logic fcn,
                         input logic [2:0] typ, input logic rdy, input logic rsp,
                         input logic [31:0] rdata);
        io_imem_req_valid     = iv;
        io_imem_req_bits_addr = ia;
        io_dmem_req_valid     = dv;
        io_dmem_req_bits_addr = da;
        io_dmem_req_bits_data = dd;
        io_dmem_req_bits_fcn  = fcn;
        io_dmem_req_bits_typ  = typ;
        mem_req_ready         = rdy;
        mem_resp_valid        = rsp;
        mem_resp_bits_data    = rdata;
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic dv,
                                input logic [31:0] da, input logic [31:0] dd, input logic fcn,
                                input logic [2:0] typ, input logic rdy, input logic rsp,
                                input logic [31:0] rdata, input logic [5:0] ef,
                                input logic cr, input logic [31:0] ea, input logic [31:0] ed,
                                input logic efcn, input logic [2:0] etyp);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dd = dd; v.fcn = fcn; v.typ = typ;
        v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.e_flags = ef; v.chk_req = cr;
        v.e_addr = ea; v.e_data = ed; v.e_fcn = efcn; v.e_typ = etyp;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Both requesters valid for n cycles; exp_i[k]=1 means imem must win cycle k.
    task automatic contend(input string name, input int n, input logic [15:0] exp_i,
                           input logic first_rsp);
        logic prev_i;
        prev_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive(1, 32'h200 + 32'(k), 1, 32'h300 + 32'(k), 32'h0, 0, 3'b010, 1,
                  (k > 0) || first_rsp, 32'h5A5A0000 + 32'(k));
            @(negedge clock);
            chk(name, 64'({io_imem_req_ready, io_dmem_req_ready,
                           io_imem_resp_valid, io_dmem_resp_valid}),
                64'({exp_i[k], !exp_i[k], (k > 0) && prev_i, (k > 0) && !prev_i}));
            prev_i = exp_i[k];
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Outputs stay quiet under reset even with everything asserted.
        drive(1, 32'h10, 1, 32'h20, 32'h30, 1, 3'b010, 1, 1, 32'h99);
        @(negedge clock);
        chk("reset_outputs", 64'(flags()), 64'(6'b000000));
        next_cycle();
        reset = 1'b0;

        //        iv ia         dv da     dd            f  typ     r  s  rdata          flags      cr addr     data          f  typ
        tbl[0]  = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 0, 0,            6'b000000, 0, 0,       0,            0, 3'b000);
        tbl[1]  = mk(1, 32'h100,  0, 0,     0,            0, 3'b000, 1, 0, 0,            6'b110000, 1, 32'h100, 0,            0, 3'b011);
        tbl[2]  = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 1, 32'h00200313, 6'b000100, 0, 0,       0,            0, 3'b000);
        tbl[3]  = mk(0, 0,        1, 32'h40, 32'hDEADBEEF, 1, 3'b010, 1, 0, 0,           6'b101000, 1, 32'h40,  32'hDEADBEEF, 1, 3'b010);
        tbl[4]  = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 1, 0,            6'b000010, 0, 0,       0,            0, 3'b000);
        tbl[5]  = mk(0, 0,        1, 32'h80, 32'h11,      0, 3'b010, 0, 0, 0,            6'b100000, 1, 32'h80,  32'h11,       0, 3'b010);
        tbl[6]  = mk(0, 0,        1, 32'h80, 32'h11,      0, 3'b010, 0, 0, 0,            6'b100000, 1, 32'h80,  32'h11,       0, 3'b010);
        tbl[7]  = mk(0, 0,        1, 32'h80, 32'h11,      0, 3'b010, 0, 0, 0,            6'b100000, 1, 32'h80,  32'h11,       0, 3'b010);
        tbl[8]  = mk(0, 0,        1, 32'h80, 32'h11,      0, 3'b010, 1, 0, 0,            6'b101000, 1, 32'h80,  32'h11,       0, 3'b010);
        tbl[9]  = mk(0, 0,        1, 32'h80, 32'h11,      0, 3'b010, 1, 0, 0,            6'b000000, 0, 0,       0,            0, 3'b000);
        tbl[10] = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 1, 32'h1234,     6'b000010, 0, 0,       0,            0, 3'b000);
        tbl[11] = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 1, 32'h7777,     6'b000000, 0, 0,       0,            0, 3'b000);
        tbl[12] = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 0, 0,            6'b000001, 0, 0,       0,            0, 3'b000);
        tbl[13] = mk(1, 32'h104,  0, 0,     0,            0, 3'b000, 1, 0, 0,            6'b110001, 1, 32'h104, 0,            0, 3'b011);
        tbl[14] = mk(0, 0,        0, 0,     0,            0, 3'b000, 1, 1, 32'hCAFE,     6'b000101, 0, 0,       0,            0, 3'b000);

        for (int r = 0; r < 15; r++) begin
            drive(tbl[r].iv, tbl[r].ia, tbl[r].dv, tbl[r].da, tbl[r].dd, tbl[r].fcn,
                  tbl[r].typ, tbl[r].rdy, tbl[r].rsp, tbl[r].rdata);
            @(negedge clock);
            chk($sformatf("tbl%0d_flags", r), 64'(flags()), 64'(tbl[r].e_flags));
            if (tbl[r].chk_req) begin
                chk($sformatf("tbl%0d_addr_data", r), {mem_req_bits_addr, mem_req_bits_data},
                    {tbl[r].e_addr, tbl[r].e_data});
                chk($sformatf("tbl%0d_fcn_typ", r), 64'({mem_req_bits_fcn, mem_req_bits_typ}),
                    64'({tbl[r].e_fcn, tbl[r].e_typ}));
            end
            if (tbl[r].e_flags[2]) chk($sformatf("tbl%0d_iresp", r), 64'(io_imem_resp_bits_data), 64'(tbl[r].rdata));
            if (tbl[r].e_flags[1]) chk($sformatf("tbl%0d_dresp", r), 64'(io_dmem_resp_bits_data), 64'(tbl[r].rdata));
            next_cycle();
        end

        // Reset clears the sticky error; it stays visible during the reset cycle itself.
        reset = 1'b1;
        drive(1, 32'h10, 1, 32'h20, 0, 0, 3'b010, 1, 1, 0);
        @(negedge clock);
        chk("reset_err_held", 64'(flags()), 64'(6'b000001));
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clock);
        chk("reset_err_cleared", 64'(flags()), 64'(6'b000000));
        next_cycle();

        contend("contention", 10, 16'b0000_0010_0001_0000, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hAB);
        @(negedge clock);
        chk("contention_drain", 64'(flags()), 64'(6'b000100));
        next_cycle();

        // Build up starvation, then reset while in BUSY_D.
        contend("pre_reset_d", 3, 16'b0, 1'b0);
        reset = 1'b1;
        drive(1, 32'h10, 1, 32'h20, 0, 0, 3'b010, 1, 0, 0);
        @(negedge clock);
        chk("reset_busy_d", 64'(flags()), 64'(6'b000000));
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hBAD);
        @(negedge clock);
        chk("late_resp_dropped", 64'(flags()), 64'(6'b000000));
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clock);
        chk("late_resp_err", 64'(flags()), 64'(6'b000001));
        next_cycle();
        contend("post_reset_starve", 5, 16'b1_0000, 1'b0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;

        // Randomized traffic against a transaction-level model.
        begin
            logic acc_i, acc_d, pending, merr, rsp, rdy, iv, dv;
            int   owner, streak, g;
            acc_i = 0; acc_d = 0; pending = 0; merr = 0; owner = 0; streak = 0;
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 3000; c++) begin
                if (!(io_imem_req_valid && !acc_i)) begin
                    io_imem_req_valid     = ($urandom % 3) != 0;
                    io_imem_req_bits_addr = $urandom;
                end
                if (!(io_dmem_req_valid && !acc_d)) begin
                    io_dmem_req_valid     = ($urandom % 3) != 0;
                    io_dmem_req_bits_addr = $urandom;
                    io_dmem_req_bits_data = $urandom;
                    io_dmem_req_bits_fcn  = 1'($urandom % 2);
                    io_dmem_req_bits_typ  = 3'($urandom % 8);
                end
                mem_req_ready      = ($urandom % 4) != 0;
                mem_resp_valid     = pending && (($urandom % 2) != 0);
                mem_resp_bits_data = $urandom;
                iv = io_imem_req_valid; dv = io_dmem_req_valid;
                rsp = mem_resp_valid; rdy = mem_req_ready;

                g = 0;
                if (owner == 0 || rsp) begin
                    if (dv && !(streak == LIMIT && iv)) g = 2;
                    else if (iv) g = 1;
                end
                @(negedge clock);
                chk("rand_flags", 64'(flags()),
                    64'({g != 0, g == 1 && rdy, g == 2 && rdy,
                         rsp && owner == 1, rsp && owner == 2, merr}));
                if (g == 2) begin
                    chk("rand_dreq", {mem_req_bits_addr, mem_req_bits_data},
                        {io_dmem_req_bits_addr, io_dmem_req_bits_data});
                    chk("rand_dctl", 64'({mem_req_bits_fcn, mem_req_bits_typ}),
                        64'({io_dmem_req_bits_fcn, io_dmem_req_bits_typ}));
                end else if (g == 1) begin
                    chk("rand_ireq", {mem_req_bits_addr, mem_req_bits_data},
                        {io_imem_req_bits_addr, 32'h0});
                    chk("rand_ictl", 64'({mem_req_bits_fcn, mem_req_bits_typ}), 64'(4'b0011));
                end
                if (rsp && owner == 1) chk("rand_iresp", 64'(io_imem_resp_bits_data), 64'(mem_resp_bits_data));
                if (rsp && owner == 2) chk("rand_dresp", 64'(io_dmem_resp_bits_data), 64'(mem_resp_bits_data));

                acc_i = (g == 1) && rdy;
                acc_d = (g == 2) && rdy;
                if (rsp && owner == 0) merr = 1;
                if (acc_i) streak = 0;
                else if (acc_d && iv) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
                if (acc_i || acc_d) begin
                    owner = g;
                    pending = 1;
                end else if (rsp) begin
                    owner = 0;
                    pending = 0;
                end
                next_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
